// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, 4-bit ALU control codes (also used by
// the ALU control decoder) and operand-forwarding select codes.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV32 ALU: result = a op b, plus a zero flag derived from
// that same result. Reserved control codes yield 0.
module alu_core #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [XLEN-1:0]   result_o,
  output logic              zero_o
);
  import alu_pkg::*;

  logic [SHAMT_W-1:0] shamt_s;
  logic [XLEN-1:0]    result_s;

  assign shamt_s = b_i[SHAMT_W-1:0];

  // Operation select; shifts only look at the low SHAMT_W bits of b
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (ctrl_i)
      ALU_ADD:  result_s = a_i + b_i;
      ALU_SUB:  result_s = a_i - b_i;
      ALU_SLL:  result_s = a_i << shamt_s;
      ALU_SLT:  result_s = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_s = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_s = a_i ^ b_i;
      ALU_SRL:  result_s = a_i >> shamt_s;
      ALU_SRA:  result_s = $unsigned($signed(a_i) >>> shamt_s);
      ALU_OR:   result_s = a_i | b_i;
      ALU_AND:  result_s = a_i & b_i;
      default:  result_s = {XLEN{1'b0}};
    endcase
  end

  assign result_o = result_s;
  assign zero_o   = (result_s == {XLEN{1'b0}});

endmodule

// File: rtl/ex_alu_stage.sv
// RV32 execute stage: ID/EX register -> alu_core -> EX/MEM register, with hazard
// stall/flush. Define EX_FWD_EN to add operand forwarding from mem_result/wb_data.
module ex_alu_stage #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EX_FWD_EN
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [XLEN-1:0]   wb_data,
`endif
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_a,
  input  logic [XLEN-1:0]   id_b,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_result,
  output logic              mem_zero,
  output logic [4:0]        mem_rd,
  output logic              mem_reg_write
);
  import alu_pkg::*;

  logic              idex_valid_q;
  logic [CTRL_W-1:0] idex_ctrl_q;
  logic [XLEN-1:0]   idex_a_q;
  logic [XLEN-1:0]   idex_b_q;
  logic [4:0]        idex_rd_q;
  logic              idex_rw_q;

  logic              exmem_valid_q;
  logic [XLEN-1:0]   exmem_result_q;
  logic              exmem_zero_q;
  logic [4:0]        exmem_rd_q;
  logic              exmem_rw_q;

  logic [XLEN-1:0]   op_a_s;
  logic [XLEN-1:0]   op_b_s;
  logic [XLEN-1:0]   alu_result_s;
  logic              alu_zero_s;

`ifdef EX_FWD_EN
  // Operand bypass; the reserved select 11 falls back to the ID/EX operand
  always_comb begin
    op_a_s = idex_a_q;
    op_b_s = idex_b_q;
    case (fwd_a_sel)
      FWD_MEM: op_a_s = exmem_result_q;
      FWD_WB:  op_a_s = wb_data;
      default: op_a_s = idex_a_q;
    endcase
    case (fwd_b_sel)
      FWD_MEM: op_b_s = exmem_result_q;
      FWD_WB:  op_b_s = wb_data;
      default: op_b_s = idex_b_q;
    endcase
  end
`else
  assign op_a_s = idex_a_q;
  assign op_b_s = idex_b_q;
`endif

  alu_core #(
    .XLEN    (XLEN),
    .CTRL_W  (CTRL_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu_core (
    .a_i      (op_a_s),
    .b_i      (op_b_s),
    .ctrl_i   (idex_ctrl_q),
    .result_o (alu_result_s),
    .zero_o   (alu_zero_s)
  );

  // ID/EX register: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_q <= 1'b0;
      idex_ctrl_q  <= {CTRL_W{1'b0}};
      idex_a_q     <= {XLEN{1'b0}};
      idex_b_q     <= {XLEN{1'b0}};
      idex_rd_q    <= 5'd0;
      idex_rw_q    <= 1'b0;
    end else if (flush) begin
      idex_valid_q <= 1'b0;
      idex_rw_q    <= 1'b0;
    end else if (stall) begin
      idex_valid_q <= idex_valid_q;
    end else begin
      idex_valid_q <= id_valid;
      idex_ctrl_q  <= id_ctrl;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      idex_rd_q    <= id_rd;
      idex_rw_q    <= id_reg_write;
    end
  end

  // EX/MEM register: rst > stall > load; write enable qualified by valid
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_valid_q  <= 1'b0;
      exmem_result_q <= {XLEN{1'b0}};
      exmem_zero_q   <= 1'b0;
      exmem_rd_q     <= 5'd0;
      exmem_rw_q     <= 1'b0;
    end else if (stall) begin
      exmem_valid_q  <= exmem_valid_q;
    end else begin
      exmem_valid_q  <= idex_valid_q;
      exmem_result_q <= alu_result_s;
      exmem_zero_q   <= alu_zero_s;
      exmem_rd_q     <= idex_rd_q;
      exmem_rw_q     <= idex_rw_q & idex_valid_q;
    end
  end

  assign mem_valid     = exmem_valid_q;
  assign mem_result    = exmem_result_q;
  assign mem_zero      = exmem_zero_q;
  assign mem_rd        = exmem_rd_q;
  assign mem_reg_write = exmem_rw_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage (forwarding cases only when
// EX_FWD_EN is defined).
module tb_ex_alu_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_ctrl;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic        mem_zero;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
`ifdef EX_FWD_EN
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] wb_data;
`endif

  int n_total;
  int n_bad;

  ex_alu_stage dut (
    .clk           (clk),
    .rst           (rst),
`ifdef EX_FWD_EN
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .wb_data       (wb_data),
`endif
    .id_valid      (id_valid),
    .id_ctrl       (id_ctrl),
    .id_a          (id_a),
    .id_b          (id_b),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_result    (mem_result),
    .mem_zero      (mem_zero),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic rw);
    id_valid = v; id_ctrl = c; id_a = a; id_b = b; id_rd = rd; id_reg_write = rw;
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[13];

  initial begin
    n_total = 0;
    n_bad   = 0;
    stall = 1'b0;
    flush = 1'b0;
`ifdef EX_FWD_EN
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    wb_data   = 32'd0;
`endif

    // Reset held two cycles with a valid instruction presented
    rst = 1'b1;
    drive(1'b1, 4'b0000, 32'd9, 32'd9, 5'd2, 1'b1);
    tick();
    tick();
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_result", mem_result, 32'd0);
    check("rst_zero", {31'd0, mem_zero}, 32'd0);
    check("rst_rd", {27'd0, mem_rd}, 32'd0);
    check("rst_rw", {31'd0, mem_reg_write}, 32'd0);

    // First instruction: 5 + 7, two-cycle latency
    rst = 1'b0;
    drive(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    check("lat1_not_yet", {31'd0, mem_valid}, 32'd0);
    tick();
    check("add_valid", {31'd0, mem_valid}, 32'd1);
    check("add_result", mem_result, 32'd12);
    check("add_rd", {27'd0, mem_rd}, 32'd3);
    check("add_rw", {31'd0, mem_reg_write}, 32'd1);
    check("add_zero", {31'd0, mem_zero}, 32'd0);

    // Every code back to back, plus wrap cases
    vecs[0]  = '{4'b0111, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0};
    vecs[1]  = '{4'b0110, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0};
    vecs[2]  = '{4'b0010, 32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 1'b1};
    vecs[3]  = '{4'b0011, 32'h8000_0000, 32'h0000_0021, 32'h0000_0001, 1'b0};
    vecs[4]  = '{4'b0100, 32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 1'b1};
    vecs[5]  = '{4'b0001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1};
    vecs[6]  = '{4'b1011, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1};
    vecs[7]  = '{4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0};
    vecs[8]  = '{4'b1000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0};
    vecs[9]  = '{4'b1001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
    vecs[10] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[11] = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    for (int i = 0; i <= 13; i++) begin
      if (i < 13) drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1);
      else        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      if (i >= 1) begin
        check($sformatf("op%0d_result", i - 1), mem_result, vecs[i-1].res);
        check($sformatf("op%0d_zero", i - 1), {31'd0, mem_zero}, {31'd0, vecs[i-1].zero});
        check($sformatf("op%0d_rd", i - 1), {27'd0, mem_rd}, 32'(i));
        check($sformatf("op%0d_valid", i - 1), {31'd0, mem_valid}, 32'd1);
      end
    end

    // Stall: drain to bubbles, issue 1+1, then stall 3 cycles with new inputs
    tick();
    check("drain_valid", {31'd0, mem_valid}, 32'd0);
    drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd5, 1'b1);
    tick();
    stall = 1'b1;
    drive(1'b1, 4'b0000, 32'd50, 32'd50, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), {31'd0, mem_valid}, 32'd0);
      check($sformatf("stall%0d_result", i), mem_result, 32'd0);
    end
    stall = 1'b0;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("unstall_valid", {31'd0, mem_valid}, 32'd1);
    check("unstall_result", mem_result, 32'd2);
    check("unstall_rd", {27'd0, mem_rd}, 32'd5);
    tick();
    check("unstall_once", {31'd0, mem_valid}, 32'd0);
    check("unstall_no_capture", mem_result, 32'd0);

    // Flush: valid instruction squashed into a bubble
    flush = 1'b1;
    drive(1'b1, 4'b0000, 32'd3, 32'd4, 5'd7, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("flush_valid", {31'd0, mem_valid}, 32'd0);
    check("flush_rw", {31'd0, mem_reg_write}, 32'd0);

    // Flush with stall: EX/MEM holds, ID/EX bubbled
    drive(1'b1, 4'b0000, 32'd2, 32'd2, 5'd4, 1'b1);
    tick();
    drive(1'b1, 4'b0000, 32'd6, 32'd6, 5'd6, 1'b1);
    tick();
    check("pre_fs_result", mem_result, 32'd4);
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 4'b0000, 32'd8, 32'd8, 5'd8, 1'b1);
    tick();
    check("fs_hold_valid", {31'd0, mem_valid}, 32'd1);
    check("fs_hold_result", mem_result, 32'd4);
    check("fs_hold_rd", {27'd0, mem_rd}, 32'd4);
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("fs_bubble_valid", {31'd0, mem_valid}, 32'd0);
    check("fs_bubble_rw", {31'd0, mem_reg_write}, 32'd0);

    // Reset mid-operation discards both in-flight instructions
    drive(1'b1, 4'b0000, 32'd1, 32'd2, 5'd1, 1'b1);
    tick();
    drive(1'b1, 4'b0000, 32'd3, 32'd4, 5'd2, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'd0, mem_valid}, 32'd0);
    tick();
    check("midrst_after_valid", {31'd0, mem_valid}, 32'd0);

`ifdef EX_FWD_EN
    // Forwarding from mem_result, wb_data, and reserved select
    drive(1'b1, 4'b0000, 32'd10, 32'd0, 5'd1, 1'b1);
    tick();
    drive(1'b1, 4'b0000, 32'd999, 32'd3, 5'd2, 1'b1);
    tick();
    fwd_a_sel = 2'b01;
    drive(1'b1, 4'b0000, 32'd1, 32'd999, 5'd3, 1'b1);
    tick();
    check("fwd_mem", mem_result, 32'd13);
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b10;
    wb_data   = 32'd100;
    drive(1'b1, 4'b0000, 32'd7, 32'd8, 5'd4, 1'b1);
    tick();
    check("fwd_wb", mem_result, 32'd101);
    fwd_b_sel = 2'b00;
    fwd_a_sel = 2'b11;
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    check("fwd_rsvd", mem_result, 32'd15);
    fwd_a_sel = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
